// File: rtl/reg_status_table.sv
`default_nettype none
// ============================================================================
//  Module      : reg_status_table
//  Description : Register-status (rename tag) table. Tracks, per architectural
//                register, whether an in-flight ROB entry will write it and the
//                tag of that entry. Answers two-operand status queries with one
//                cycle of latency. Optional macro REG_STATUS_COMMIT_BYPASS_EN
//                lets a query see a same-cycle matching commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_status_table #(
    parameter int ROB_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic [ROB_WIDTH-1:0] issue_tag,
    input  logic                 query_valid,
    input  logic [4:0]           query_rs1,
    input  logic [4:0]           query_rs2,
    input  logic                 commit_valid,
    input  logic [4:0]           commit_rd,
    input  logic [ROB_WIDTH-1:0] commit_tag,
    output logic                 ans_valid,
    output logic                 ans_rs1_busy,
    output logic [ROB_WIDTH-1:0] ans_rs1_tag,
    output logic                 ans_rs2_busy,
    output logic [ROB_WIDTH-1:0] ans_rs2_tag,
    output logic [5:0]           busy_cnt
);

    localparam int c_num_regs = 32;

    // Table state. Bit 0 of r_busy is never written, so x0 always reads clear.
    logic [c_num_regs-1:0] r_busy;
    logic [ROB_WIDTH-1:0]  r_tag [c_num_regs];
    logic [5:0]            r_busy_cnt;

    logic                  r_ans_valid;
    logic                  r_ans_rs1_busy;
    logic [ROB_WIDTH-1:0]  r_ans_rs1_tag;
    logic                  r_ans_rs2_busy;
    logic [ROB_WIDTH-1:0]  r_ans_rs2_tag;

    logic                  w_issue_set;
    logic                  w_commit_hit;
    logic                  w_same_rd;
    logic                  w_commit_clr;
    logic                  w_cnt_inc;
    logic [5:0]            w_cnt_next;

    // Issue to x0 is dropped; commit only clears when it is still the youngest
    // writer of that register (tag match), otherwise a newer rename exists.
    assign w_issue_set  = issue_valid && (issue_rd != 5'd0);
    assign w_commit_hit = commit_valid && (commit_rd != 5'd0) &&
                          r_busy[commit_rd] && (r_tag[commit_rd] == commit_tag);
    assign w_same_rd    = w_issue_set && (issue_rd == commit_rd);
    // A same-register issue overrides the commit, so the bit stays set.
    assign w_commit_clr = w_commit_hit && !w_same_rd;
    assign w_cnt_inc    = w_issue_set && !r_busy[issue_rd];
    assign w_cnt_next   = r_busy_cnt + {5'd0, w_cnt_inc} - {5'd0, w_commit_clr};

    // Query lookup, one copy per source operand. Reads pre-issue state.
    logic [4:0]           w_rs     [2];
    logic [1:0]           w_q_busy;
    logic [ROB_WIDTH-1:0] w_q_tag  [2];

    assign w_rs[0] = query_rs1;
    assign w_rs[1] = query_rs2;

    for (genvar gp = 0; gp < 2; gp++) begin : g_query
`ifdef REG_STATUS_COMMIT_BYPASS_EN
        // A register retired this very cycle must not make RS wait.
        logic w_commit_match;
        assign w_commit_match = w_commit_hit && (commit_rd == w_rs[gp]);
        assign w_q_busy[gp]   = r_busy[w_rs[gp]] && !w_commit_match;
`else
        assign w_q_busy[gp]   = r_busy[w_rs[gp]];
`endif
        assign w_q_tag[gp]    = (w_rs[gp] == 5'd0) ? '0 : r_tag[w_rs[gp]];
    end

    // Busy bits and tags: flush clears everything, issue wins over commit.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy <= '0;
            for (int i = 0; i < c_num_regs; i++) begin
                r_tag[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                r_busy <= '0;
            end else begin
                if (w_commit_clr) begin
                    r_busy[commit_rd] <= 1'b0;
                end
                if (w_issue_set) begin
                    r_busy[issue_rd] <= 1'b1;
                    r_tag[issue_rd]  <= issue_tag;
                end
            end
        end
    end

    // Running count of busy registers, kept in step with the table updates.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy_cnt <= 6'd0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_busy_cnt <= 6'd0;
            end else begin
                r_busy_cnt <= w_cnt_next;
            end
        end
    end

    // Registered query answer; fields hold between accepted queries.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_ans_valid    <= 1'b0;
            r_ans_rs1_busy <= 1'b0;
            r_ans_rs1_tag  <= '0;
            r_ans_rs2_busy <= 1'b0;
            r_ans_rs2_tag  <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_ans_valid <= 1'b0;
            end else begin
                r_ans_valid <= query_valid;
                if (query_valid) begin
                    r_ans_rs1_busy <= w_q_busy[0];
                    r_ans_rs1_tag  <= w_q_tag[0];
                    r_ans_rs2_busy <= w_q_busy[1];
                    r_ans_rs2_tag  <= w_q_tag[1];
                end
            end
        end
    end

    assign ans_valid    = r_ans_valid;
    assign ans_rs1_busy = r_ans_rs1_busy;
    assign ans_rs1_tag  = r_ans_rs1_tag;
    assign ans_rs2_busy = r_ans_rs2_busy;
    assign ans_rs2_tag  = r_ans_rs2_tag;
    assign busy_cnt     = r_busy_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_status_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_status_table
//  Description : Self-checking bench for reg_status_table. Directed scenarios
//                with literal expectations, then randomized traffic checked
//                every cycle against a behavioural table model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_status_table;

    localparam int RW = 3;
`ifdef REG_STATUS_COMMIT_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    logic          clk_in;
    logic          rst_in;
    logic          rdy_in;
    logic          flush_in;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [RW-1:0] issue_tag;
    logic          query_valid;
    logic [4:0]    query_rs1;
    logic [4:0]    query_rs2;
    logic          commit_valid;
    logic [4:0]    commit_rd;
    logic [RW-1:0] commit_tag;
    logic          ans_valid;
    logic          ans_rs1_busy;
    logic [RW-1:0] ans_rs1_tag;
    logic          ans_rs2_busy;
    logic [RW-1:0] ans_rs2_tag;
    logic [5:0]    busy_cnt;

    reg_status_table #(.ROB_WIDTH(RW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .query_valid(query_valid), .query_rs1(query_rs1), .query_rs2(query_rs2),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .ans_valid(ans_valid), .ans_rs1_busy(ans_rs1_busy), .ans_rs1_tag(ans_rs1_tag),
        .ans_rs2_busy(ans_rs2_busy), .ans_rs2_tag(ans_rs2_tag), .busy_cnt(busy_cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0] m_busy = '0;
    int        m_tag [32];
    bit        m_av = 0, m_b1 = 0, m_b2 = 0, m_t1c = 0, m_t2c = 0;
    int        m_t1 = 0, m_t2 = 0;

    initial for (int i = 0; i < 32; i++) m_tag[i] = 0;

    function automatic bit retired_now(input int r);
        return commit_valid && r != 0 && int'(commit_rd) == r &&
               m_busy[r] && m_tag[r] == int'(commit_tag);
    endfunction

    // Table semantics: answer from pre-cycle state, then apply commit, then
    // issue (so a same-register issue overrides the commit).
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            m_busy = '0;
            for (int i = 0; i < 32; i++) m_tag[i] = 0;
            m_av = 0; m_b1 = 0; m_b2 = 0; m_t1 = 0; m_t2 = 0; m_t1c = 0; m_t2c = 0;
        end else if (rdy_in) begin
            if (flush_in) begin
                m_busy = '0;
                m_av   = 0;
            end else begin
                int r1, r2, cr, ir;
                bit ret1, ret2;
                r1 = int'(query_rs1);
                r2 = int'(query_rs2);
                ret1 = c_byp && retired_now(r1);
                ret2 = c_byp && retired_now(r2);
                m_av = query_valid;
                if (query_valid) begin
                    m_b1  = (r1 != 0) && m_busy[r1] && !ret1;
                    m_b2  = (r2 != 0) && m_busy[r2] && !ret2;
                    m_t1  = (r1 == 0) ? 0 : m_tag[r1];
                    m_t2  = (r2 == 0) ? 0 : m_tag[r2];
                    m_t1c = m_b1 || (r1 == 0);
                    m_t2c = m_b2 || (r2 == 0);
                end
                cr = int'(commit_rd);
                if (retired_now(cr)) m_busy[cr] = 1'b0;
                ir = int'(issue_rd);
                if (issue_valid && ir != 0) begin
                    m_busy[ir] = 1'b1;
                    m_tag[ir]  = int'(issue_tag);
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("cmp_ans_valid", int'(ans_valid), int'(m_av));
            chk("cmp_busy_cnt", int'(busy_cnt), $countones(m_busy));
            chk("cmp_rs1_busy", int'(ans_rs1_busy), int'(m_b1));
            chk("cmp_rs2_busy", int'(ans_rs2_busy), int'(m_b2));
            if (m_t1c) chk("cmp_rs1_tag", int'(ans_rs1_tag), m_t1);
            if (m_t2c) chk("cmp_rs2_tag", int'(ans_rs2_tag), m_t2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        flush_in = 0; issue_valid = 0; issue_rd = 0; issue_tag = 0;
        query_valid = 0; query_rs1 = 0; query_rs2 = 0;
        commit_valid = 0; commit_rd = 0; commit_tag = 0;
    endtask

    task automatic do_issue(input int rd, input int tg);
        idle(); issue_valid = 1; issue_rd = 5'(rd); issue_tag = RW'(tg);
        cyc(); idle();
    endtask

    task automatic do_commit(input int rd, input int tg);
        idle(); commit_valid = 1; commit_rd = 5'(rd); commit_tag = RW'(tg);
        cyc(); idle();
    endtask

    task automatic do_query(input int r1, input int r2);
        idle(); query_valid = 1; query_rs1 = 5'(r1); query_rs2 = 5'(r2);
        cyc(); idle();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; idle();
        repeat (3) cyc();
        chk("rst_ans_valid", int'(ans_valid), 0);
        chk("rst_busy_cnt", int'(busy_cnt), 0);
        chk("rst_rs1_busy", int'(ans_rs1_busy), 0);
        rst_in = 1'b0;
        chk_en = 1'b1;

        // Fresh table: everything clear.
        do_query(5, 0);
        chk("t1_valid", int'(ans_valid), 1);
        chk("t1_rs1_busy", int'(ans_rs1_busy), 0);
        chk("t1_rs2_busy", int'(ans_rs2_busy), 0);
        chk("t1_rs2_tag", int'(ans_rs2_tag), 0);
        chk("t1_cnt", int'(busy_cnt), 0);

        // Simple rename.
        do_issue(5, 3);
        do_query(5, 0);
        chk("t2_rs1_busy", int'(ans_rs1_busy), 1);
        chk("t2_rs1_tag", int'(ans_rs1_tag), 3);
        chk("t2_cnt", int'(busy_cnt), 1);

        // WAW: stale commit keeps younger writer.
        do_issue(5, 6);
        do_commit(5, 3);
        do_query(5, 0);
        chk("t3_rs1_busy", int'(ans_rs1_busy), 1);
        chk("t3_rs1_tag", int'(ans_rs1_tag), 6);
        chk("t3_cnt", int'(busy_cnt), 1);
        do_commit(5, 6);
        do_query(5, 0);
        chk("t3_clear_busy", int'(ans_rs1_busy), 0);
        chk("t3_clear_cnt", int'(busy_cnt), 0);

        // Issue + commit + query on the same register in one cycle.
        do_issue(7, 2);
        issue_valid = 1; issue_rd = 7; issue_tag = 4;
        commit_valid = 1; commit_rd = 7; commit_tag = 2;
        query_valid = 1; query_rs1 = 7;
        cyc(); idle();
        chk("t4_ans_busy", int'(ans_rs1_busy), c_byp ? 0 : 1);
        if (!c_byp) chk("t4_ans_tag", int'(ans_rs1_tag), 2);
        chk("t4_cnt", int'(busy_cnt), 1);
        do_query(7, 0);
        chk("t4_after_busy", int'(ans_rs1_busy), 1);
        chk("t4_after_tag", int'(ans_rs1_tag), 4);

        // x0 is never renamed.
        issue_valid = 1; issue_rd = 0; issue_tag = 1;
        query_valid = 1; query_rs2 = 0; query_rs1 = 0;
        cyc(); idle();
        chk("t5_rs2_busy", int'(ans_rs2_busy), 0);
        chk("t5_rs2_tag", int'(ans_rs2_tag), 0);
        chk("t5_cnt", int'(busy_cnt), 1);

        // Flush discards same-cycle issue and query.
        for (int r = 1; r <= 4; r++) do_issue(r, r);
        chk("t6_pre_cnt", int'(busy_cnt), 5);
        flush_in = 1; issue_valid = 1; issue_rd = 9; issue_tag = 5;
        query_valid = 1; query_rs1 = 1; query_rs2 = 9;
        cyc(); idle();
        chk("t6_valid", int'(ans_valid), 0);
        chk("t6_cnt", int'(busy_cnt), 0);
        do_query(1, 9);
        chk("t6_rs1_busy", int'(ans_rs1_busy), 0);
        chk("t6_rs2_busy", int'(ans_rs2_busy), 0);
        cyc();

        // Frozen while rdy_in is low.
        rdy_in = 0; issue_valid = 1; issue_rd = 3; issue_tag = 5;
        query_valid = 1; query_rs1 = 3;
        repeat (3) cyc();
        chk("t7_cnt", int'(busy_cnt), 0);
        chk("t7_valid", int'(ans_valid), 0);
        rdy_in = 1; idle();
        do_query(3, 0);
        chk("t7_rs1_busy", int'(ans_rs1_busy), 0);

        // Asynchronous reset mid-operation.
        do_issue(10, 1);
        chk("t8_pre_cnt", int'(busy_cnt), 1);
        rst_in = 1;
        #2;
        chk("t8_async_cnt", int'(busy_cnt), 0);
        cyc();
        rst_in = 0;

        // Fill every register: counter tops out at 31.
        for (int r = 1; r < 32; r++) do_issue(r, r % 8);
        chk("t9_full_cnt", int'(busy_cnt), 31);
        do_issue(5, 2);
        chk("t9_rewrite_cnt", int'(busy_cnt), 31);
        do_query(31, 1);
        chk("t9_rs1_tag", int'(ans_rs1_tag), 7);
        chk("t9_rs2_tag", int'(ans_rs2_tag), 1);
        flush_in = 1; cyc(); idle();

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            int cr;
            rdy_in       = ($urandom_range(0, 9) != 0);
            flush_in     = ($urandom_range(0, 39) == 0);
            issue_valid  = $urandom_range(0, 1);
            issue_rd     = 5'($urandom_range(0, 15));
            issue_tag    = RW'($urandom);
            commit_valid = $urandom_range(0, 1);
            cr = ($urandom_range(0, 1) != 0) ? int'(issue_rd) : $urandom_range(0, 15);
            commit_rd    = 5'(cr);
            commit_tag   = ($urandom_range(0, 3) != 0) ? RW'(m_tag[cr]) : RW'($urandom);
            query_valid  = $urandom_range(0, 1);
            query_rs1    = ($urandom_range(0, 2) == 0) ? commit_rd : 5'($urandom_range(0, 15));
            query_rs2    = 5'($urandom_range(0, 15));
            cyc();
        end
        idle(); rdy_in = 1;
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
